// File: rtl/mgmt_gpio_in_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : mgmt_gpio_in_sampler_if
//  Purpose  : Bundles the pad-input, configuration, status-clear and result
//             signals of mgmt_gpio_in_sampler.
//             master : housekeeping/pad side (drives pins, config, clear)
//             slave  : the sampler itself (drives level, status, irq)
//  Signals  : mgmt_gpio_in_buf [N_IO]   asynchronous buffered pad inputs
//             debounce_limit   [DBNC_W] commit after limit+1 stable cycles
//             rise_en/fall_en  [N_IO]   per-pin edge capture enables
//             clr_valid        [1]      strobe applying clr_mask
//             clr_mask         [N_IO]   write-1-to-clear mask for edge_status
//             gpio_level       [N_IO]   debounced level per pin
//             edge_status      [N_IO]   sticky captured-edge bits
//             irq              [1]      OR of edge_status
//  Revision : 1.0  initial release
// ============================================================================
interface mgmt_gpio_in_sampler_if #(
    parameter int N_IO   = 19,
    parameter int DBNC_W = 8
);
    logic [N_IO-1:0]   mgmt_gpio_in_buf;
    logic [DBNC_W-1:0] debounce_limit;
    logic [N_IO-1:0]   rise_en;
    logic [N_IO-1:0]   fall_en;
    logic              clr_valid;
    logic [N_IO-1:0]   clr_mask;
    logic [N_IO-1:0]   gpio_level;
    logic [N_IO-1:0]   edge_status;
    logic              irq;

    modport master (
        output mgmt_gpio_in_buf, debounce_limit, rise_en, fall_en, clr_valid, clr_mask,
        input  gpio_level, edge_status, irq
    );

    modport slave (
        input  mgmt_gpio_in_buf, debounce_limit, rise_en, fall_en, clr_valid, clr_mask,
        output gpio_level, edge_status, irq
    );
endinterface
`default_nettype wire

// File: rtl/mgmt_gpio_in_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : mgmt_gpio_in_sampler
//  Purpose  : Receive-side conditioning of the management GPIO pad inputs:
//             multi-flop synchroniser, per-pin debounce, enabled rise/fall
//             capture into sticky status bits and a level interrupt.
//  Ports    : wb_clk_i  clock for the whole block
//             wb_rst_i  synchronous active-high reset
//             bus       mgmt_gpio_in_sampler_if.slave (pins, config, clear,
//                       gpio_level, edge_status, irq)
//  Notes    : N_IO / DBNC_W must match the parameters of the connected
//             interface instance.
//  Revision : 1.0  initial release
// ============================================================================
module mgmt_gpio_in_sampler #(
    parameter int N_IO        = 19,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_W      = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    mgmt_gpio_in_sampler_if.slave   bus
);

    // A single-flop chain is not a synchroniser; clamp to the minimum depth.
    localparam int c_SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_SYNC_DEPTH-1:0][N_IO-1:0] r_sync;
    logic [N_IO-1:0][DBNC_W-1:0]       r_cnt;
    logic [N_IO-1:0]                   r_level;
    logic [N_IO-1:0]                   r_status;

    logic [N_IO-1:0] w_sync;
    logic [N_IO-1:0] w_mismatch;
    logic [N_IO-1:0] w_commit;
    logic [N_IO-1:0] w_set;
    logic [N_IO-1:0] w_clr;
    logic [N_IO-1:0] w_status_nxt;

    // ------------------------------------------------------------------
    // Synchroniser: new samples enter at index 0, last stage is the output.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_SYNC_DEPTH-2:0], bus.mgmt_gpio_in_buf};
        end
    end

    assign w_sync     = r_sync[c_SYNC_DEPTH-1];
    assign w_mismatch = w_sync ^ r_level;

    // ------------------------------------------------------------------
    // Debounce commit: the >= compare lets a mid-count reduction of the
    // limit commit immediately instead of letting the counter run away.
    // A limit of 0 commits on the very first mismatched cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_commit = '0;
        for (int i = 0; i < N_IO; i++) begin
            w_commit[i] = w_mismatch[i] && (r_cnt[i] >= bus.debounce_limit);
        end
    end

    // Edge events exist only on the commit cycle, so enables are sampled there.
    assign w_set = w_commit & ((w_sync & bus.rise_en) | (~w_sync & bus.fall_en));
    assign w_clr = bus.clr_valid ? bus.clr_mask : '0;

    // Set is OR-ed after the clear so a same-cycle collision keeps the bit.
    assign w_status_nxt = (r_status & ~w_clr) | w_set;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt    <= '0;
            r_level  <= '0;
            r_status <= '0;
        end else begin
            for (int i = 0; i < N_IO; i++) begin
                // Matching input (bounce back) or a commit restarts the count;
                // the counter is bounded by the limit so it never wraps.
                if (!w_mismatch[i] || w_commit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DBNC_W'(1);
                end
            end
            r_level  <= r_level ^ w_commit;
            r_status <= w_status_nxt;
        end
    end

    assign bus.gpio_level  = r_level;
    assign bus.edge_status = r_status;
    assign bus.irq         = |r_status;

endmodule
`default_nettype wire
